// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM state encoding and
// default parameter values.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_MAX_BURST  = 4;

endpackage

// File: rtl/rr_pick.sv
// Cyclic first-valid search: returns the first asserted bit of valid at or
// after rr_ptr, wrapping around NUM_REQ.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
    localparam int unsigned IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IW-1:0]      rr_ptr,
    output logic [IW-1:0]      index,
    output logic               any
);

    int unsigned pos;

    always_comb begin
        index = '0;
        any   = 1'b0;
        pos   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = int'(rr_ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (!any && valid[IW'(pos)]) begin
                any   = 1'b1;
                index = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin burst arbiter feeding a single FIFO write port from NUM_REQ
// requesters; accepted beats are written one cycle after acceptance.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int unsigned MAX_BURST  = DEF_MAX_BURST,
    localparam int unsigned GW         = $clog2(NUM_REQ),
    localparam int unsigned CW         = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_w_en,
    output logic [DATA_WIDTH-1:0]         fifo_w_data,
    input  logic                          fifo_full,
    input  logic                          fifo_almost_full,
    output logic [GW-1:0]                 grant_id,
    output logic                          grant_active
);

    arb_state_e            state, state_nxt;
    logic [GW-1:0]         rr_ptr;
    logic [GW-1:0]         pick_idx;
    logic                  pick_any;
    logic [CW-1:0]         beat_cnt;
    logic                  grant_valid;
    logic                  grant_ok;
    logic                  accept;
    logic                  last_beat;
    logic [DATA_WIDTH-1:0] grant_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .valid  (req_valid),
        .rr_ptr (rr_ptr),
        .index  (pick_idx),
        .any    (pick_any)
    );

    // A write already in flight with almost_full set would fill the FIFO, so
    // a further beat must be held off for that cycle.
    always_comb begin
        grant_valid = req_valid[grant_id];
        grant_data  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (GW'(k) == grant_id) begin
                grant_data = req_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        grant_ok  = !fifo_full && !(fifo_w_en && fifo_almost_full);
        accept    = (state == BURST) && grant_valid && grant_ok && !rst;
        last_beat = (beat_cnt == CW'(MAX_BURST - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = BURST;
                end
            end
            BURST: begin
                if (!grant_valid || (accept && last_beat)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant_active = (state == BURST);
        req_ready    = '0;
        if (state == BURST && !rst) begin
            req_ready[grant_id] = grant_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            beat_cnt    <= '0;
            grant_id    <= '0;
            fifo_w_en   <= 1'b0;
            fifo_w_data <= '0;
        end else begin
            fifo_w_en <= accept;
            if (accept) begin
                fifo_w_data <= grant_data;
                beat_cnt    <= beat_cnt + 1'b1;
            end
            if (state == BURST && state_nxt == IDLE) begin
                rr_ptr <= (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
            if (state == IDLE && pick_any) begin
                grant_id <= pick_idx;
                beat_cnt <= '0;
            end
        end
    end

endmodule
